// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK-cell based synchronous counter: per-bit cell mode
// and the J/K input encoding that realises each mode.
package jk_counter_pkg;

   // Per-bit action requested of a JK cell on the next rising edge.
   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      RESET  = 2'd1,
      SET    = 2'd2,
      TOGGLE = 2'd3
   } jk_mode_e;

   // J/K encoding per mode, packed as {J, K}.
   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   // Translate a cell mode into its {J, K} pair.
   function automatic logic [1:0] jk_encode(input jk_mode_e mode);
      logic [1:0] jk;
      unique case (mode)
         HOLD:    jk = JK_HOLD;
         RESET:   jk = JK_RESET;
         SET:     jk = JK_SET;
         TOGGLE:  jk = JK_TOGGLE;
         default: jk = JK_HOLD;
      endcase
      return jk;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-low reset. Pure storage element:
// it knows nothing about counting.
module jk_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);

   logic q_q;
   logic q_d;

   // Classic JK next-state: hold, reset, set or toggle.
   always_comb begin
      q_d = q_q;
      unique case ({j, k})
         2'b00:   q_d = q_q;
         2'b01:   q_d = 1'b0;
         2'b10:   q_d = 1'b1;
         2'b11:   q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   // State register; reset is sampled on the clock edge only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q    = q_q;
   assign qbar = ~q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MODULUS up/down counter with parallel load, built from one JK cell per
// bit. Each cell is steered by a per-bit mode mux (hold / set-reset / toggle);
// the toggle chain and the wrap handling live here, the cells only store.
module jk_sync_counter
   import jk_counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 2 ** WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qbar,
   output logic             tc
);

   // With a full-range modulus the natural binary toggle chain already wraps
   // correctly; otherwise the wrap edge is forced with set/reset.
   localparam bit               FullRange = (MODULUS == (2 ** WIDTH));
   localparam logic [WIDTH-1:0] MaxVal    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   ModVal    = (WIDTH + 1)'(MODULUS);

   logic [WIDTH-1:0] cell_q;
   logic [WIDTH-1:0] cell_qbar;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] wrap_val;
   logic [WIDTH-1:0] tgl_up;
   logic [WIDTH-1:0] tgl_dn;
   logic [WIDTH-1:0] tgl;
   logic             at_max;
   logic             at_zero;
   logic             wrap_load;

   assign at_max  = (cell_q == MaxVal);
   assign at_zero = (cell_q == '0);

   // Terminal count: the next enabled count step would wrap.
   assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

   // Out-of-range load values collapse to zero so q never leaves 0..MODULUS-1.
   assign load_val = ({1'b0, d} >= ModVal) ? '0 : d;

   assign wrap_val  = up ? '0 : MaxVal;
   assign wrap_load = tc & ~FullRange;

   // Ripple-free toggle enables: bit i flips when all lower bits are 1 (up)
   // or all lower bits are 0 (down).
   always_comb begin
      tgl_up    = '0;
      tgl_dn    = '0;
      tgl_up[0] = 1'b1;
      tgl_dn[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         tgl_up[i] = tgl_up[i-1] & cell_q[i-1];
         tgl_dn[i] = tgl_dn[i-1] & cell_qbar[i-1];
      end
      tgl = up ? tgl_up : tgl_dn;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_mode_e   mode;
      logic [1:0] jk;

      // Per-bit mode mux: load beats count, count beats hold.
      always_comb begin
         mode = HOLD;
         if (load) begin
            mode = load_val[i] ? SET : RESET;
         end else if (en) begin
            if (wrap_load) begin
               mode = wrap_val[i] ? SET : RESET;
            end else if (tgl[i]) begin
               mode = TOGGLE;
            end
         end
      end

      assign jk = jk_encode(mode);

      jk_cell u_cell (
         .clk  (clk),
         .rst_n(rst_n),
         .j    (jk[1]),
         .k    (jk[0]),
         .q    (cell_q[i]),
         .qbar (cell_qbar[i])
      );
   end

   assign q    = cell_q;
   assign qbar = cell_qbar;

endmodule
